boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl.sv | 154 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// UART boot loader: receives a 32-bit word count and that many 32-bit words
// (MSB-first), writes them to memory from BASE_ADDR, then hands memory to the CPU.
module boot_loader_ctrl #(
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_ferr,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_stall,
  output logic        boot_done,
  output logic        boot_err
);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_ERR
  } bootState_e;

  bootState_e  state_q, state_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] addr_q, addr_d;

  logic        byteOk;
  logic        byteBad;
  logic [31:0] lenNext;

  assign byteOk  = rx_valid && !rx_ferr;
  assign byteBad = rx_valid && rx_ferr;
  assign lenNext = {len_q[23:0], rx_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_LEN;
      byteCnt_q   <= 2'd0;
      len_q       <= 32'd0;
      remaining_q <= 32'd0;
      shift_q     <= 32'd0;
      addr_q      <= BASE_ADDR;
    end else begin
      state_q     <= state_d;
      byteCnt_q   <= byteCnt_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byteCnt_d   = byteCnt_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    cpu_stall   = 1'b1;
    boot_done   = 1'b0;
    boot_err    = 1'b0;

    case (state_q)
      ST_LEN: begin
        if (byteBad) begin
          state_d = ST_ERR;
        end else if (byteOk) begin
          len_d     = lenNext;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            if (lenNext == 32'd0) begin
              state_d = ST_RUN;
            end else if (lenNext > 32'(MAX_WORDS)) begin
              state_d = ST_ERR;
            end else begin
              state_d     = ST_DATA;
              addr_d      = BASE_ADDR;
              remaining_d = lenNext;
            end
          end
        end
      end

      ST_DATA: begin
        if (byteBad) begin
          state_d = ST_ERR;
        end else if (byteOk) begin
          shift_d   = {shift_q[23:0], rx_data};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end

      // A byte arriving during the write is the first byte of the next word.
      ST_WRITE: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = addr_q;
        mem_wdata   = shift_q;
        addr_d      = addr_q + 32'd1;
        remaining_d = remaining_q - 32'd1;
        if (byteBad) begin
          state_d = ST_ERR;
        end else if (remaining_q == 32'd1) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DATA;
          if (byteOk) begin
            shift_d   = {shift_q[23:0], rx_data};
            byteCnt_d = byteCnt_q + 2'd1;
          end
        end
      end

      ST_RUN: begin
        cpu_stall = 1'b0;
        boot_done = 1'b1;
        mem_en    = cpu_en;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end

      ST_ERR: begin
        boot_err = 1'b1;
      end

      default: begin
        state_d = ST_LEN;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: directed scenarios plus randomized
// loads compared against a byte-stream model of the expected memory writes.
module tb_boot_loader_ctrl;

  localparam int unsigned MAX_WORDS = 4096;
  localparam logic [31:0] BASE_ADDR = 32'd0;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  logic        cpu_en;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        boot_done;
  logic        boot_err;

  int checks;
  int failures;
  int leaks;
  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];

  boot_loader_ctrl #(
    .MAX_WORDS(MAX_WORDS),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ferr(rx_ferr),
    .cpu_en(cpu_en),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loader writes are recorded whenever the CPU is held; any other activity
  // on the memory port while held is counted as a leak.
  always @(negedge clk) begin
    if (rstn && cpu_stall) begin
      if (mem_en && mem_we) begin
        obsAddr.push_back(mem_addr);
        obsData.push_back(mem_wdata);
      end else if (mem_en || mem_we || mem_addr != 32'd0 || mem_wdata != 32'd0) begin
        leaks++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic ferr);
    rx_data   = data;
    rx_ferr   = ferr;
    rx_valid  = 1'b1;
    cpu_en    = 1'($urandom);
    cpu_we    = 1'($urandom);
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) applyStimulus(w[8*b +: 8], 1'b0);
  endtask

  task automatic resetDut();
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    rstn     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    obsAddr.delete();
    obsData.delete();
    leaks = 0;
  endtask

  task automatic checkWrites(input string tag, input logic [31:0] words[$]);
    checkOutput({tag, "_count"}, 32'(obsAddr.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < obsAddr.size(); i++) begin
      checkOutput({tag, "_addr"}, obsAddr[i], BASE_ADDR + 32'(i));
      checkOutput({tag, "_data"}, obsData[i], words[i]);
    end
    checkOutput({tag, "_leaks"}, 32'(leaks), 32'd0);
  endtask

  // Expected writes follow from the byte stream alone: a load of N words
  // produces words 0..N-1 at BASE_ADDR+i unless N is out of range or a framing
  // error hits byte k, in which case only the words completed before k land.
  task automatic runLoad(input logic [31:0] n, input int ferrAt, input int gapMax);
    logic [7:0]  bytes[$];
    logic [31:0] words[$];
    logic [31:0] expWords[$];
    logic [31:0] w;
    int          nData;
    int          expWr;
    bit          expErr;
    resetDut();
    for (int b = 3; b >= 0; b--) bytes.push_back(n[8*b +: 8]);
    nData = (n > MAX_WORDS) ? 2 : int'(n);
    for (int i = 0; i < nData; i++) begin
      w = $urandom;
      words.push_back(w);
      for (int b = 3; b >= 0; b--) bytes.push_back(w[8*b +: 8]);
    end
    expErr = (n > MAX_WORDS) || (ferrAt >= 0);
    if (n > MAX_WORDS)  expWr = 0;
    else if (ferrAt >= 0) expWr = (ferrAt < 4) ? 0 : (ferrAt - 4) / 4;
    else                expWr = nData;
    for (int i = 0; i < expWr; i++) expWords.push_back(words[i]);

    for (int i = 0; i < bytes.size(); i++) begin
      idleCycles($urandom_range(0, gapMax));
      applyStimulus(bytes[i], i == ferrAt);
    end
    idleCycles(3);
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1'b0);
    idleCycles(2);

    checkWrites("rnd", expWords);
    checkOutput("rnd_bootErr", 32'(boot_err), 32'(expErr));
    checkOutput("rnd_bootDone", 32'(boot_done), 32'(!expErr));
    checkOutput("rnd_stall", 32'(cpu_stall), 32'(expErr));
    if (!expErr) begin
      cpu_en    = 1'($urandom);
      cpu_we    = 1'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      #1;
      checkOutput("rnd_mirrorAddr", mem_addr, cpu_addr);
      checkOutput("rnd_mirrorData", mem_wdata, cpu_wdata);
      checkOutput("rnd_mirrorCtl", {30'd0, mem_en, mem_we}, {30'd0, cpu_en, cpu_we});
    end
  endtask

  initial begin
    logic [31:0] exp[$];
    logic [31:0] n;
    int          r;
    checks    = 0;
    failures  = 0;
    leaks     = 0;
    rstn      = 1'b0;
    rx_valid  = 1'b0;
    rx_ferr   = 1'b0;
    rx_data   = 8'h00;
    cpu_en    = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h1234_5678;
    cpu_wdata = 32'hCAFE_F00D;

    // Outputs while reset is held, with CPU inputs active.
    #12;
    checkOutput("rst_stall", 32'(cpu_stall), 32'd1);
    checkOutput("rst_done", 32'(boot_done), 32'd0);
    checkOutput("rst_err", 32'(boot_err), 32'd0);
    checkOutput("rst_memCtl", {30'd0, mem_en, mem_we}, 32'd0);
    checkOutput("rst_memAddr", mem_addr, 32'd0);
    checkOutput("rst_memData", mem_wdata, 32'd0);

    // Two-word load with an idle cycle between words.
    resetDut();
    sendWord(32'd2);
    sendWord(32'hDEAD_BEEF);
    checkOutput("w0_we", 32'(mem_we), 32'd1);
    checkOutput("w0_addr", mem_addr, 32'd0);
    checkOutput("w0_data", mem_wdata, 32'hDEAD_BEEF);
    idleCycles(1);
    checkOutput("w0_oneCycle", 32'(mem_we), 32'd0);
    sendWord(32'h0123_4567);
    checkOutput("w1_stall", 32'(cpu_stall), 32'd1);
    idleCycles(1);
    checkOutput("w1_stallAfter", 32'(cpu_stall), 32'd0);
    checkOutput("w1_done", 32'(boot_done), 32'd1);
    exp = '{32'hDEAD_BEEF, 32'h0123_4567};
    checkWrites("two", exp);

    // Zero-length load goes straight to RUN.
    resetDut();
    cpu_we = 1'b0;
    sendWord(32'd0);
    checkOutput("zero_done", 32'(boot_done), 32'd1);
    idleCycles(3);
    exp.delete();
    checkWrites("zero", exp);

    // One word past the limit is rejected.
    resetDut();
    sendWord(32'h0000_1001);
    checkOutput("over_err", 32'(boot_err), 32'd1);
    checkOutput("over_stall", 32'(cpu_stall), 32'd1);
    sendWord(32'h1122_3344);
    sendWord(32'h5566_7788);
    idleCycles(2);
    checkWrites("over", exp);
    checkOutput("over_errHold", 32'(boot_err), 32'd1);

    // Byte arriving in the WRITE cycle starts the next word.
    resetDut();
    sendWord(32'd2);
    sendWord(32'hA1B2_C3D4);
    checkOutput("ovl_we", 32'(mem_we), 32'd1);
    sendWord(32'h1122_3344);
    checkOutput("ovl_addr", mem_addr, 32'd1);
    checkOutput("ovl_data", mem_wdata, 32'h1122_3344);
    idleCycles(2);
    exp = '{32'hA1B2_C3D4, 32'h1122_3344};
    checkWrites("ovl", exp);

    // Framing error on the third data byte.
    resetDut();
    sendWord(32'd2);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b1);
    applyStimulus(8'hDD, 1'b0);
    idleCycles(2);
    checkOutput("ferr_err", 32'(boot_err), 32'd1);
    exp.delete();
    checkWrites("ferr", exp);

    // CPU pass-through in RUN, then reset mid-DATA and mid-WRITE.
    resetDut();
    sendWord(32'd1);
    sendWord(32'h0BAD_F00D);
    idleCycles(1);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hAA;
    #1;
    checkOutput("run_memCtl", {30'd0, mem_en, mem_we}, 32'd3);
    checkOutput("run_memAddr", mem_addr, 32'd5);
    checkOutput("run_memData", mem_wdata, 32'hAA);

    resetDut();
    sendWord(32'd3);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    rstn = 1'b0;
    #1;
    checkOutput("midData_stall", 32'(cpu_stall), 32'd1);
    checkOutput("midData_memCtl", {30'd0, mem_en, mem_we}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    obsAddr.delete(); obsData.delete(); leaks = 0;
    sendWord(32'd1);
    sendWord(32'h1234_5678);
    idleCycles(2);
    exp = '{32'h1234_5678};
    checkWrites("restart", exp);
    checkOutput("restart_done", 32'(boot_done), 32'd1);

    resetDut();
    sendWord(32'd2);
    sendWord(32'h9999_8888);
    rstn = 1'b0;
    #1;
    checkOutput("midWrite_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    obsAddr.delete(); obsData.delete(); leaks = 0;
    sendWord(32'd1);
    sendWord(32'h7777_6666);
    idleCycles(2);
    exp = '{32'h7777_6666};
    checkWrites("restartW", exp);

    // Largest accepted length, streamed back-to-back.
    runLoad(32'(MAX_WORDS), -1, 0);

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = 32'd0;
      else if (r == 1) n = 32'(MAX_WORDS) + 32'd1 + 32'($urandom_range(0, 100));
      else if (r == 2) n = 32'hFFFF_FFFF;
      else             n = 32'($urandom_range(1, 5));
      if (n <= MAX_WORDS && $urandom_range(0, 9) < 3)
        runLoad(n, $urandom_range(0, 4 + 4 * int'(n) - 1), $urandom_range(0, 2));
      else
        runLoad(n, -1, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
